// File: rtl/fetch_sequencer_if.sv
// Core-side delivery channel of the fetch sequencer.
// Head-of-queue instruction and its PC, valid/ready handshake.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
);
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives imem,
// buffers fetched instructions in a 2-entry prefetch queue.
module fetch_sequencer #(
    parameter int                 ADDR_W    = 4,
    parameter int                 INSTR_W   = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 8'hF0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    fetch_sequencer_if.master  core,
    output logic               running
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  next_pc_q, next_pc_d;
    logic [ADDR_W-1:0]  q_pc_q [2];
    logic [ADDR_W-1:0]  q_pc_d [2];
    logic [INSTR_W-1:0] q_ins_q [2];
    logic [INSTR_W-1:0] q_ins_d [2];
    logic [1:0]         count_q, count_d;

    logic              is_run;
    logic              pop;
    logic              push;
    logic              do_halt;
    logic [1:0]        keep_cnt;
    logic [ADDR_W-1:0] base_pc;

    assign is_run  = (state_q == RUN);
    assign pop     = (count_q != 2'd0) && core.instr_ready;
    assign do_halt = is_run && halt && !redirect_valid;
    assign push    = is_run && !redirect_valid && !halt
                   && ((count_q != 2'd2) || pop);

    // Resume point: first instruction not yet taken by the core.
    assign base_pc  = pop ? q_pc_q[0] + ADDR_W'(1) : next_pc_q;
    assign keep_cnt = count_q - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (do_halt) state_d = HALTED;
            HALTED:  if (start)   state_d = RUN;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == RUN);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        next_pc_d  = next_pc_q;
        count_d    = count_q;
        q_pc_d[0]  = pop ? q_pc_q[1]  : q_pc_q[0];
        q_pc_d[1]  = q_pc_q[1];
        q_ins_d[0] = pop ? q_ins_q[1] : q_ins_q[0];
        q_ins_d[1] = q_ins_q[1];
        unique case (1'b1)
            redirect_valid: begin
                count_d    = 2'd0;
                fetch_pc_d = redirect_pc;
                next_pc_d  = redirect_pc;
            end
            do_halt: begin
                count_d    = 2'd0;
                fetch_pc_d = base_pc;
                next_pc_d  = base_pc;
            end
            default: begin
                next_pc_d = base_pc;
                count_d   = keep_cnt;
                if (push) begin
                    q_pc_d[keep_cnt[0]]  = fetch_pc_q;
                    q_ins_d[keep_cnt[0]] = imem_instr;
                    count_d    = keep_cnt + 2'd1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= '0;
            next_pc_q  <= '0;
            count_q    <= 2'd0;
            q_pc_q[0]  <= '0;
            q_pc_q[1]  <= '0;
            q_ins_q[0] <= '0;
            q_ins_q[1] <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            next_pc_q  <= next_pc_d;
            count_q    <= count_d;
            q_pc_q[0]  <= q_pc_d[0];
            q_pc_q[1]  <= q_pc_d[1];
            q_ins_q[0] <= q_ins_d[0];
            q_ins_q[1] <= q_ins_d[1];
        end
    end

    assign imem_addr        = fetch_pc_q;
    assign core.instr_valid = (count_q != 2'd0);
    assign core.instr_out   = core.instr_valid ? q_ins_q[0] : NOP_INSTR;
    assign core.instr_pc    = core.instr_valid ? q_pc_q[0]  : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       redirect_valid;
    logic [3:0] redirect_pc;
    logic [3:0] imem_addr;
    logic [7:0] imem_instr;
    logic       running;
    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] ins;
    } ent_t;

    ent_t       mq[$];
    bit         mrun;
    logic [3:0] mfpc;
    logic [3:0] mnpc;

    fetch_sequencer_if #(.ADDR_W(4), .INSTR_W(8)) bus ();

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .core           (bus),
        .running        (running)
    );

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mrun = 1'b0;
        mfpc = 4'd0;
        mnpc = 4'd0;
    endtask

    // Compare outputs against the model, then apply this cycle's inputs
    // to the model and advance one clock.
    task automatic cyc(int n = 1);
        for (int k = 0; k < n; k++) begin
            chk("valid", bus.instr_valid, (mq.size() != 0));
            chk("instr", bus.instr_out,
                mq.size() != 0 ? mq[0].ins : 8'hF0);
            chk("pc", bus.instr_pc,
                mq.size() != 0 ? mq[0].pc : 4'd0);
            chk("imem_addr", imem_addr, mfpc);
            chk("running", running, mrun);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (mq.size() != 0 && bus.instr_ready) begin
                    mnpc = mq[0].pc + 4'd1;
                    void'(mq.pop_front());
                end
                if (redirect_valid) begin
                    mq.delete();
                    mfpc = redirect_pc;
                    mnpc = redirect_pc;
                    if (!mrun && start) mrun = 1'b1;
                end else if (mrun && halt) begin
                    mq.delete();
                    mfpc = mnpc;
                    mrun = 1'b0;
                end else if (mrun) begin
                    if (mq.size() < 2) begin
                        mq.push_back('{pc: mfpc, ins: mem[mfpc]});
                        mfpc = mfpc + 4'd1;
                    end
                end else if (start) begin
                    mrun = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_head(logic [3:0] pc);
        int n = 0;
        while (!(mq.size() != 0 && mq[0].pc == pc) && n < 40) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $error("FAIL wait_head observed=timeout expected=pc%0d", pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        rst_n = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 4'd0;
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cyc(1);
        chk("rst_nop", bus.instr_out, 8'hF0);
        rst_n = 1'b1;

        // Start and stream through a full wrap.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("lat1_valid", bus.instr_valid, 1'b0);
        chk("lat1_run", running, 1'b1);
        cyc(1);
        chk("lat2_valid", bus.instr_valid, 1'b1);
        chk("lat2_pc", bus.instr_pc, 8'd0);
        cyc(18);

        // Backpressure from a fresh start.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        bus.instr_ready = 1'b0;
        cyc(5);
        chk("bp_addr", imem_addr, 8'd2);
        chk("bp_hold", bus.instr_out, 8'h10);
        bus.instr_ready = 1'b1;
        cyc(3);

        // Redirect while pc 3 is accepted.
        wait_head(4'd3);
        redirect_valid = 1'b1;
        redirect_pc = 4'd9;
        cyc(1);
        redirect_valid = 1'b0;
        chk("bubble", bus.instr_valid, 1'b0);
        cyc(1);
        chk("redir_pc", bus.instr_pc, 8'd9);
        cyc(2);

        // Halt with pc 5 at the head, unaccepted.
        redirect_valid = 1'b1;
        redirect_pc = 4'd4;
        cyc(1);
        redirect_valid = 1'b0;
        wait_head(4'd5);
        bus.instr_ready = 1'b0;
        halt = 1'b1;
        cyc(1);
        halt = 1'b0;
        chk("halt_addr", imem_addr, 8'd5);
        chk("halt_run", running, 1'b0);
        cyc(3);
        bus.instr_ready = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("resume_pc", bus.instr_pc, 8'd5);
        cyc(2);

        // Redirect beats halt.
        redirect_valid = 1'b1;
        halt = 1'b1;
        redirect_pc = 4'd12;
        cyc(1);
        redirect_valid = 1'b0;
        halt = 1'b0;
        chk("rh_run", running, 1'b1);
        cyc(1);
        chk("rh_pc", bus.instr_pc, 8'd12);
        cyc(2);

        // Reset mid-stream with a full queue.
        bus.instr_ready = 1'b0;
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        bus.instr_ready = 1'b1;

        // Random traffic with new memory contents.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 1500; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = 4'($urandom);
            halt = ($urandom_range(0, 24) == 0);
            start = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller between the 16-entry instruction memory and the CPU decode stage. Owns the program counter, drives the memory's 4-bit address, and buffers fetched bytes in a 2-entry prefetch queue delivered to the core over a valid/ready handshake. Handles start, jump/branch redirect and halt so the core never addresses instruction memory directly.

## Interface
- ADDR_W, 4, instruction address width (16 instructions)
- INSTR_W, 8, instruction width
- NOP_INSTR, 8'hF0, value driven on instr_out whenever instr_valid=0
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- start  input  1  pulse: leave IDLE/HALTED and begin fetching
- halt  input  1  level/pulse: stop fetching and flush the queue
- redirect_valid  input  1  jump/branch taken this cycle
- redirect_pc  input  ADDR_W  jump target
- imem_addr  output  ADDR_W  address to instruction memory (= fetch_pc)
- imem_instr  input  INSTR_W  combinational read data for imem_addr
- instr_out  output  INSTR_W  instruction at queue head
- instr_pc  output  ADDR_W  address of instr_out
- instr_valid  output  1  queue non-empty
- instr_ready  input  1  core accepts head this cycle
- running  output  1  state == RUN

## Operation
- States: IDLE (after reset), RUN, HALTED. IDLE -start-> RUN; RUN -halt-> HALTED; HALTED -start-> RUN. No other transitions.
- Registers: fetch_pc, next_pc (address of next instruction to be delivered), queue of 2 {pc, instr} entries, count 0..2.
- Pop: instr_valid && instr_ready; next_pc <= instr_pc + 1 (mod 16).
- Push: state==RUN && no redirect/halt this cycle && (count<2 || pop). Entry = {fetch_pc, imem_instr}; fetch_pc <= fetch_pc + 1, wrapping 15 -> 0. Simultaneous push and pop keeps count unchanged.
- instr_valid = (count != 0); instr_out/instr_pc = head entry, else NOP_INSTR / 0.
- Redirect (any state): queue flushed, count <= 0, fetch_pc <= redirect_pc, next_pc <= redirect_pc. State unchanged. Any pop in the same cycle still counts as accepted by the core.
- Halt (RUN only): queue flushed, state <= HALTED, fetch_pc <= next_pc after this cycle's pop adjustment, so resume refetches the first undelivered instruction. Halt in IDLE/HALTED is ignored.
- Priority, highest first: rst_n=0, redirect_valid, halt, start. Redirect with start in IDLE/HALTED: both apply (target loaded, enter RUN).
- Start while in RUN is ignored.

## Timing
- Reset (rst_n low at an edge): state IDLE, fetch_pc=0, next_pc=0, count=0, imem_addr=0, instr_valid=0, instr_out=8'hF0, instr_pc=0, running=0. Reset mid-fetch discards the queue with no pending output.
- Start sampled at edge N: running=1 after N; first push at edge N+1; instr_valid=1 after N+1 (2-cycle start latency).
- Steady state with instr_ready=1: one instruction per cycle, consecutive instr_pc values, wrapping 15 -> 0.
- instr_ready=0: queue fills to 2 after two pushes; fetch_pc stalls; head and instr_out remain stable until accepted.
- Redirect at edge E: instr_valid=0 during cycle E+1; target pushed at E+1; valid after E+1 (exactly one bubble).
- Halt at edge H: instr_valid=0 and running=0 from H onward; imem_addr holds the resume address.
- Outputs are registered except imem_addr (= fetch_pc register) and instr_out/instr_pc muxed from queue registers; no combinational path from instr_ready to any output other than through the registers.

## Test plan
- Reset then start with instr_ready=1, memory preloaded 0x10..0x1F: instr_valid rises 2 cycles after start; instr_pc 0,1,2,…,15,0 with instr_out 0x10…0x1F, 0x10.
- Backpressure: instr_ready=0 for 5 cycles after first valid: count reaches 2, imem_addr stops at 2, instr_out holds 0x10; release gives pc 0,1,2 with no loss or duplication.
- Redirect to pc 9 while delivering pc 3 (accepted): one bubble cycle, next delivered instr_pc=9, then 10; pc 4 never delivered.
- Halt while head is pc 5 unaccepted: running=0, instr_valid=0, imem_addr=5; start resumes and first delivered instr_pc=5.
- Simultaneous redirect_valid=1 (target 12) and halt=1 in RUN: redirect wins, stays RUN, next instr_pc=12.
- rst_n=0 asserted for one edge mid-stream with queue full: all outputs at reset values next cycle, state IDLE, no output until a new start.
